nrisc_boot_loader: RTL



---
 rtl/nrisc_boot_loader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/nrisc_boot_loader.sv
// Loads a framed byte stream (A5, LEN_H, LEN_L, payload, XOR checksum) into instruction memory, then releases the core.
// Latency: imem_we fires one cycle after a word's last byte is accepted; done/err follow the deciding byte by one cycle.
// Backpressure: none while receiving (rx_ready high in every receive state); rx_ready drops in RUN/ERR until reload.
module nrisc_boot_loader #(
    parameter int TAM     = 16,
    parameter int N_IData = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic               reload,
    output logic [N_IData-1:0] imem_addr,
    output logic [TAM-1:0]     imem_data,
    output logic               imem_we,
    output logic               core_hold,
    output logic               done,
    output logic               err
);
    localparam int BPW = TAM / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int SHW = (TAM > 8) ? TAM - 8 : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_H, S_LEN_L, S_DATA, S_CHK, S_RUN, S_ERR
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       len_h;
    logic [15:0]      len;
    logic [N_IData:0] word_idx;
    logic [BCW-1:0]   byte_cnt;
    logic [SHW-1:0]   word_sh;
    logic [7:0]       xor_acc;

    logic             take;
    logic             last_byte;
    logic             last_word;
    logic [15:0]      len_full;
    logic [TAM-1:0]   word_nxt;

    assign take      = rx_valid & rx_ready;
    assign last_byte = (byte_cnt == BCW'(BPW - 1));
    assign last_word = ((32'(word_idx) + 32'd1) == 32'(len));
    assign len_full  = {len_h, rx_data};
    // Only the low TAM-8 bits need keeping: the oldest byte leaves on the word's last byte.
    assign word_nxt  = TAM'({word_sh, rx_data});

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (take && rx_data == 8'hA5) state_nxt = S_LEN_H;
            S_LEN_H: if (take) state_nxt = S_LEN_L;
            S_LEN_L: if (take) begin
                if (32'(len_full) > (32'd1 << N_IData)) state_nxt = S_ERR;
                else if (len_full == 16'd0)            state_nxt = S_CHK;
                else                                   state_nxt = S_DATA;
            end
            S_DATA:  if (take && last_byte && last_word) state_nxt = S_CHK;
            S_CHK:   if (take) state_nxt = (rx_data == xor_acc) ? S_RUN : S_ERR;
            S_RUN,
            S_ERR:   if (reload) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they change one cycle after the deciding event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            rx_ready  <= 1'b0;
            core_hold <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            rx_ready  <= (state_nxt != S_RUN) && (state_nxt != S_ERR);
            core_hold <= (state_nxt != S_RUN);
            done      <= (state_nxt == S_RUN);
            err       <= (state_nxt == S_ERR);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_h     <= '0;
            len       <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            word_sh   <= '0;
            xor_acc   <= '0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_data <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    word_idx <= '0;
                    byte_cnt <= '0;
                    word_sh  <= '0;
                    xor_acc  <= '0;
                end
                S_LEN_H: if (take) len_h <= rx_data;
                S_LEN_L: if (take) len <= len_full;
                S_DATA: if (take) begin
                    xor_acc <= xor_acc ^ rx_data;
                    if (last_byte) begin
                        imem_we   <= 1'b1;
                        imem_data <= word_nxt;
                        imem_addr <= word_idx[N_IData-1:0];
                        word_idx  <= word_idx + 1'b1;
                        byte_cnt  <= '0;
                        word_sh   <= '0;
                    end else begin
                        word_sh  <= word_nxt[SHW-1:0];
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
